fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
- Owns the single write port of the pixel frame-buffer memory (address/colour/write-strobe) and shares it between two pixel requesters, e.g. the button painter and a pattern/sprite generator.
- Contains a built-in clear sequencer that sweeps every pixel address with a fixed colour.
- Sits between the game-logic blocks and the frame-buffer RAM that the VGA scan-out reads.

Parameters:
- AW, 8, pixel address width.
- DW, 3, pixel colour width (RGB 1-1-1).
- NPIX, 192, number of valid pixel addresses (0..NPIX-1).
- CLR_COLOR, 3'b111, colour written by the clear sweep.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- clr_start  in  1  one-cycle request to start a full clear sweep.
- clr_busy  out  1  high while the clear sweep owns the port.
- clr_done  out  1  one-cycle pulse after the last clear write.
- r0_valid  in  1  requester 0 has a pixel write pending.
- r0_addr  in  AW  requester 0 pixel address.
- r0_data  in  DW  requester 0 colour.
- r0_ready  out  1  requester 0 accepted this cycle.
- r1_valid, r1_addr, r1_data, r1_ready: same as requester 0, for requester 1.
- addr_err  out  1  one-cycle pulse: an accepted request had addr >= NPIX.
- mem_px_addr  out  AW  frame-buffer write address (registered).
- mem_px_data  out  DW  frame-buffer write colour (registered).
- px_wr  out  1  frame-buffer write strobe (registered).

Behaviour:
- Single clock (clk). rst is synchronous and active-high.
- Reset values:
  - mem_px_addr=0, mem_px_data=0, px_wr=0.
  - clr_busy=0, clr_done=0, addr_err=0.
  - State IDLE, clear counter 0.
  - Round-robin pointer last=1, so r0 wins the first contention.
- State machine, two states, IDLE and CLEAR:
  - IDLE -> CLEAR when clr_start=1. clr_busy goes high the next cycle.
  - CLEAR -> IDLE after the write to address NPIX-1 is issued.
- Ready signals:
  - Combinational from state, valids, clr_start and the pointer.
  - At most one ready is high per cycle.
  - A transfer occurs when rN_valid and rN_ready are both high in the same cycle.
- IDLE arbitration:
  - If clr_start=1: both readies are 0. Clear wins; the request stays pending.
  - Else if only one valid is high: that requester is ready.
  - Else if both are high: the requester other than last is ready, and last is updated to the winner.
  - last updates only on an accepted transfer.
- Write latency:
  - A transfer accepted in cycle t drives px_wr=1, mem_px_addr=rN_addr and mem_px_data=rN_data in cycle t+1.
  - With continuous valid, one write is issued per cycle.
- Out-of-range address:
  - A request with addr >= NPIX is still accepted (ready=1) and the handshake completes.
  - In t+1: px_wr=0 and addr_err=1. The memory is not written.
- No transfer in a cycle: px_wr=0 in the next cycle. mem_px_addr and mem_px_data hold their previous values.
- CLEAR sweep:
  - Both readies are 0.
  - One write per cycle: addresses 0,1,...,NPIX-1, colour CLR_COLOR, px_wr=1.
  - The first clear write appears the cycle after clr_start is sampled; NPIX consecutive writes follow.
  - clr_busy is high for exactly those NPIX cycles.
  - clr_done pulses in the cycle after the address NPIX-1 write. The block is back in IDLE and readies may assert in that same cycle.
- clr_start while in CLEAR is ignored; there is no restart or queueing.
- The clear counter is AW+1 bits wide, so NPIX=2^AW does not overflow.
- The counter resets to 0 at each sweep start.
- Reset mid-sweep:
  - Aborts immediately to the reset values.
  - No clr_done pulse is generated.
  - The remaining addresses are left unwritten.
- Requesters must hold addr, data and valid stable until ready. The arbiter does not check this.

Test Plan:
- Reset check: assert rst 2 cycles with r0_valid=1 -> px_wr=0, r0_ready=0, clr_busy=0, all outputs 0 during reset.
- Single write: r0_valid=1, addr=5, data=3'b010 for one cycle in IDLE -> r0_ready=1 that cycle; next cycle px_wr=1, mem_px_addr=5, mem_px_data=3'b010; the following cycle px_wr=0.
- Contention: r0 and r1 both valid continuously for 4 cycles with distinct addrs 10 and 20 -> grants r0,r1,r0,r1; px_wr writes to 10,20,10,20.
- Clear sweep: pulse clr_start -> 192 consecutive px_wr cycles, addresses 0..191, data 3'b111, clr_busy high for 192 cycles, readies 0 throughout, clr_done single pulse after address 191. A clr_start pulse mid-sweep changes nothing.
- Collision: clr_start=1 in the same cycle as r1_valid=1 -> r1_ready=0 through the sweep; r1 is accepted in the cycle clr_done pulses; its write appears one cycle later.
- Error and abort cases:
  - r0 addr=200 -> r0_ready=1, next cycle addr_err=1 and px_wr=0.
  - rst at sweep address 50 -> px_wr=0 and clr_busy=0 next cycle, no clr_done.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port arbiter: two round-robin pixel requesters plus a
// built-in clear sweep that paints every pixel with CLR_COLOR.
module fb_write_arbiter #(
  parameter int              AW        = 8,
  parameter int              DW        = 3,
  parameter int              NPIX      = 192,
  parameter logic [DW-1:0]   CLR_COLOR = 3'b111
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  input  logic          r0_valid,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_data,
  output logic          r0_ready,
  input  logic          r1_valid,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_data,
  output logic          r1_ready,
  output logic          addr_err,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state, state_nxt;
  logic [AW:0]   cnt;        // address currently on the port during a sweep
  logic [AW:0]   cnt_inc;
  logic          clr_last;
  logic          last;       // 1: r1 won the most recent contention
  logic          xfer;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          in_range;

  assign cnt_inc  = cnt + 1'b1;
  assign clr_last = (cnt == (AW+1)'(NPIX - 1));
  assign clr_busy = (state == CLEAR);
  assign xfer     = r0_ready | r1_ready;
  assign sel_addr = r1_ready ? r1_addr : r0_addr;
  assign sel_data = r1_ready ? r1_data : r0_data;
  assign in_range = ({1'b0, sel_addr} < (AW+1)'(NPIX));

  // Next state and ready grants; a pending clear always beats requesters.
  always_comb begin
    state_nxt = state;
    r0_ready  = 1'b0;
    r1_ready  = 1'b0;
    if (state == IDLE) begin
      if (clr_start) begin
        state_nxt = CLEAR;
      end else if (!rst) begin
        r0_ready = r0_valid & (~r1_valid | last);
        r1_ready = r1_valid & ~(r0_valid & (~r1_valid | last));
      end
    end else if (clr_last) begin
      state_nxt = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Registered write port, sweep counter, round-robin pointer and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_px_addr <= '0;
      mem_px_data <= '0;
      px_wr       <= 1'b0;
      addr_err    <= 1'b0;
      clr_done    <= 1'b0;
      cnt         <= '0;
      last        <= 1'b1;
    end else begin
      px_wr    <= 1'b0;
      addr_err <= 1'b0;
      clr_done <= 1'b0;
      if (state == IDLE) begin
        if (clr_start) begin
          cnt         <= '0;
          mem_px_addr <= '0;
          mem_px_data <= CLR_COLOR;
          px_wr       <= 1'b1;
        end else if (xfer) begin
          last <= r1_ready;
          if (in_range) begin
            mem_px_addr <= sel_addr;
            mem_px_data <= sel_data;
            px_wr       <= 1'b1;
          end else begin
            addr_err <= 1'b1;
          end
        end
      end else begin
        if (clr_last) begin
          clr_done <= 1'b1;
        end else begin
          cnt         <= cnt_inc;
          mem_px_addr <= cnt_inc[AW-1:0];
          mem_px_data <= CLR_COLOR;
          px_wr       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a queue model.
module tb_fb_write_arbiter;
  localparam int NPIX = 192;
  localparam int CLRC = 7;

  logic       clk = 1'b0, rst = 1'b1, clr_start = 1'b0;
  logic       r0_valid = 1'b0, r1_valid = 1'b0;
  logic [7:0] r0_addr = '0, r1_addr = '0;
  logic [2:0] r0_data = '0, r1_data = '0;
  logic       clr_busy, clr_done, r0_ready, r1_ready, addr_err, px_wr;
  logic [7:0] mem_px_addr;
  logic [2:0] mem_px_data;

  fb_write_arbiter dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy),
    .clr_done(clr_done), .r0_valid(r0_valid), .r0_addr(r0_addr),
    .r0_data(r0_data), .r0_ready(r0_ready), .r1_valid(r1_valid),
    .r1_addr(r1_addr), .r1_data(r1_data), .r1_ready(r1_ready),
    .addr_err(addr_err), .mem_px_addr(mem_px_addr),
    .mem_px_data(mem_px_data), .px_wr(px_wr)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Model state: what the port must show this cycle, and the sweep as a
  // plain list of addresses still to be written.
  int  clr_q[$];
  bit  m_busy = 0, m_last = 1;
  bit  e_wr = 0, e_err = 0, e_done = 0;
  int  e_addr = 0, e_data = 0;
  // Observation logs for the directed scenarios.
  int  wlog[$], glog[$];
  int  cyc = 0, busy_cnt = 0, done_cnt = 0, err_cnt = 0, done_cyc = -1, g1_cyc = -2;

  // Compare process: outputs are stable here, inputs for the next edge set.
  always @(negedge clk) begin
    bit e_r0, e_r1;
    int a, d;
    #2;
    cyc++;
    e_r0 = 0; e_r1 = 0;
    if (!rst && !m_busy && !clr_start) begin
      if (r0_valid && (!r1_valid || m_last)) e_r0 = 1;
      else if (r1_valid)                     e_r1 = 1;
    end
    chk("r0_ready", int'(r0_ready), int'(e_r0));
    chk("r1_ready", int'(r1_ready), int'(e_r1));
    chk("px_wr", int'(px_wr), int'(e_wr));
    chk("mem_px_addr", int'(mem_px_addr), e_addr);
    chk("mem_px_data", int'(mem_px_data), e_data);
    chk("clr_busy", int'(clr_busy), int'(m_busy));
    chk("clr_done", int'(clr_done), int'(e_done));
    chk("addr_err", int'(addr_err), int'(e_err));
    if (px_wr)    wlog.push_back(int'(mem_px_addr) * 8 + int'(mem_px_data));
    if (clr_busy) busy_cnt++;
    if (clr_done) begin done_cnt++; done_cyc = cyc; end
    if (addr_err) err_cnt++;
    if (r0_valid && r0_ready) glog.push_back(0);
    if (r1_valid && r1_ready) begin glog.push_back(1); g1_cyc = cyc; end
    // Advance the model across the coming edge.
    e_err = 0; e_done = 0; e_wr = 0;
    if (rst) begin
      e_addr = 0; e_data = 0; m_busy = 0; m_last = 1; clr_q.delete();
    end else if (m_busy) begin
      if (clr_q.size() == 0) begin
        m_busy = 0; e_done = 1;
      end else begin
        e_wr = 1; e_addr = clr_q.pop_front(); e_data = CLRC;
      end
    end else if (clr_start) begin
      for (int i = 0; i < NPIX; i++) clr_q.push_back(i);
      e_wr = 1; e_addr = clr_q.pop_front(); e_data = CLRC; m_busy = 1;
    end else if (e_r0 || e_r1) begin
      a = e_r0 ? int'(r0_addr) : int'(r1_addr);
      d = e_r0 ? int'(r0_data) : int'(r1_data);
      m_last = e_r1;
      if (a < NPIX) begin e_wr = 1; e_addr = a; e_data = d; end
      else e_err = 1;
    end
  end

  task automatic clr_logs();
    wlog.delete(); glog.delete();
    busy_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  initial begin
    int  bad, found;
    bit  acc, acc0, acc1, pend0, pend1;
    int  exp_g[4], exp_a[4];
    exp_g = '{0, 1, 0, 1};
    exp_a = '{10, 20, 10, 20};

    // Reset held two cycles with a requester already valid.
    rst = 1; r0_valid = 1; r0_addr = 8'd5; r0_data = 3'b010;
    @(negedge clk); #3;
    chk("rst_px_wr", int'(px_wr), 0);
    chk("rst_r0_ready", int'(r0_ready), 0);
    chk("rst_clr_busy", int'(clr_busy), 0);
    chk("rst_mem_addr", int'(mem_px_addr), 0);
    @(negedge clk);
    // Single write to address 5.
    clr_logs();
    rst = 0;
    @(negedge clk); r0_valid = 0;
    repeat (3) @(negedge clk); #3;
    chk("single_nwrites", wlog.size(), 1);
    if (wlog.size() > 0) chk("single_write", wlog[0], 5 * 8 + 2);

    // Contention from a fresh reset: r0 wins first, then alternate.
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);
    rst = 0; clr_logs();
    r0_valid = 1; r0_addr = 8'd10; r0_data = 3'd1;
    r1_valid = 1; r1_addr = 8'd20; r1_data = 3'd4;
    repeat (4) @(negedge clk);
    r0_valid = 0; r1_valid = 0;
    repeat (2) @(negedge clk); #3;
    chk("cont_ngrants", glog.size(), 4);
    chk("cont_nwrites", wlog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < glog.size()) chk("cont_grant", glog[i], exp_g[i]);
      if (i < wlog.size()) chk("cont_addr", wlog[i] / 8, exp_a[i]);
    end

    // Full clear sweep, with an ignored clr_start in the middle.
    @(negedge clk); clr_logs(); clr_start = 1;
    @(negedge clk); clr_start = 0;
    repeat (100) @(negedge clk);
    clr_start = 1;
    @(negedge clk); clr_start = 0;
    repeat (100) @(negedge clk); #3;
    bad = 0;
    for (int i = 0; i < wlog.size(); i++) if (wlog[i] != i * 8 + CLRC) bad++;
    chk("clr_nwrites", wlog.size(), NPIX);
    chk("clr_seq_bad", bad, 0);
    chk("clr_busy_cycles", busy_cnt, NPIX);
    chk("clr_done_pulses", done_cnt, 1);

    // Clear collides with r1; r1 granted in the clr_done cycle.
    @(negedge clk); clr_logs();
    clr_start = 1; r1_valid = 1; r1_addr = 8'd30; r1_data = 3'd5;
    acc = 0;
    for (int i = 0; i < 300 && !acc; i++) begin
      #3; if (r1_ready) acc = 1;
      @(negedge clk); clr_start = 0;
    end
    r1_valid = 0;
    chk("coll_accept_in_time", int'(acc), 1);
    repeat (2) @(negedge clk); #3;
    chk("coll_grant_at_done", g1_cyc, done_cyc);
    chk("coll_nwrites", wlog.size(), NPIX + 1);
    if (wlog.size() > 0) chk("coll_write", wlog[wlog.size()-1], 30 * 8 + 5);

    // Out-of-range address: accepted, flagged, not written.
    @(negedge clk); clr_logs();
    r0_valid = 1; r0_addr = 8'd200; r0_data = 3'd3;
    @(negedge clk); r0_valid = 0;
    repeat (2) @(negedge clk); #3;
    chk("err_pulses", err_cnt, 1);
    chk("err_nwrites", wlog.size(), 0);
    chk("err_ngrants", glog.size(), 1);

    // Reset while the sweep shows address 50.
    @(negedge clk); clr_logs(); clr_start = 1;
    @(negedge clk); clr_start = 0;
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      #3; if (px_wr && mem_px_addr == 8'd49) found = 1;
      @(negedge clk);
    end
    chk("abort_reached_49", found, 1);
    rst = 1;
    @(negedge clk); rst = 0;
    repeat (3) @(negedge clk); #3;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_nwrites", wlog.size(), 51);

    // Randomized traffic; each requester holds its request until accepted.
    acc0 = 0; acc1 = 0; pend0 = 0; pend1 = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (acc0) pend0 = 0;
      if (acc1) pend1 = 0;
      rst       = ($urandom_range(0, 499) == 0);
      clr_start = ($urandom_range(0, 199) == 0);
      if (!pend0 && $urandom_range(0, 1) == 1) begin
        pend0 = 1; r0_addr = 8'($urandom_range(0, 255)); r0_data = 3'($urandom);
      end
      if (!pend1 && $urandom_range(0, 1) == 1) begin
        pend1 = 1; r1_addr = 8'($urandom_range(0, 255)); r1_data = 3'($urandom);
      end
      r0_valid = pend0; r1_valid = pend1;
      #3;
      acc0 = r0_valid && r0_ready;
      acc1 = r1_valid && r1_ready;
    end

    @(negedge clk);
    rst = 0; clr_start = 0; r0_valid = 0; r1_valid = 0;
    repeat (2) @(negedge clk); #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
